// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle for the two doubleword requesters of data_mem_ctrl.
// master = requester side, slave = controller side.
interface data_mem_ctrl_if;
    logic        req0_valid;
    logic        req0_ready;
    logic        req0_we;
    logic [63:0] req0_addr;
    logic [63:0] req0_wdata;
    logic        rsp0_valid;
    logic        rsp0_err;
    logic [63:0] rsp0_rdata;

    logic        req1_valid;
    logic        req1_ready;
    logic        req1_we;
    logic [63:0] req1_addr;
    logic [63:0] req1_wdata;
    logic        rsp1_valid;
    logic        rsp1_err;
    logic [63:0] rsp1_rdata;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_err, rsp1_rdata
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_err, rsp1_rdata
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Two-port round-robin arbiter that serialises 64-bit load/store requests
// into eight little-endian byte accesses on a single byte-wide memory port.
module data_mem_ctrl #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    data_mem_ctrl_if.slave    bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       buf_q, buf_d;
    logic [63:0]       rdata0_q, rdata0_d;
    logic [63:0]       rdata1_q, rdata1_d;

    logic              grant;
    logic              sel_valid;
    logic              sel_we;
    logic [63:0]       sel_addr;
    logic [63:0]       sel_wdata;
    logic              accept;
    logic              out_of_range;

    // On a tie the port that was not served last wins.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = bus.req1_valid;
        end
        sel_valid    = grant ? bus.req1_valid : bus.req0_valid;
        sel_we       = grant ? bus.req1_we    : bus.req0_we;
        sel_addr     = grant ? bus.req1_addr  : bus.req0_addr;
        sel_wdata    = grant ? bus.req1_wdata : bus.req0_wdata;
        accept       = (state_q == IDLE) && sel_valid;
        out_of_range = sel_addr > 64'(DEPTH - 8);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            base_q       <= '0;
            wdata_q      <= '0;
            buf_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            err_q        <= err_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            buf_q        <= buf_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = out_of_range ? RESP : XFER;
            XFER:    if (cnt_q == 3'd7) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        err_d        = err_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        buf_d        = buf_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        if (accept) begin
            port_d       = grant;
            last_grant_d = grant;
            we_d         = sel_we;
            err_d        = out_of_range;
            base_d       = sel_addr[ADDR_W-1:0];
            wdata_d      = sel_wdata;
            cnt_d        = '0;
            if (out_of_range) begin
                if (grant) rdata1_d = '0;
                else       rdata0_d = '0;
            end
        end else if (state_q == XFER) begin
            cnt_d = cnt_q + 3'd1;
            // The last byte lands in the response register on the same edge it is read.
            if (!we_q) begin
                buf_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
                if (cnt_q == 3'd7) begin
                    if (port_q) rdata1_d = buf_d;
                    else        rdata0_d = buf_d;
                end
            end
        end
    end

    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.rsp0_err   = 1'b0;
        bus.rsp1_err   = 1'b0;
        mem_addr       = '0;
        mem_we         = 1'b0;
        mem_wdata      = '0;
        busy           = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by reset so ready stays low while reset is held.
                bus.req0_ready = reset_n && bus.req0_valid && !grant;
                bus.req1_ready = reset_n && bus.req1_valid && grant;
            end
            XFER: begin
                busy      = 1'b1;
                mem_addr  = base_q + ADDR_W'(cnt_q);
                mem_we    = we_q;
                mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
            end
            RESP: begin
                busy = 1'b1;
                if (port_q) begin
                    bus.rsp1_valid = 1'b1;
                    bus.rsp1_err   = err_q;
                end else begin
                    bus.rsp0_valid = 1'b1;
                    bus.rsp0_err   = err_q;
                end
            end
            default: ;
        endcase
    end

    assign bus.rsp0_rdata = rdata0_q;
    assign bus.rsp1_rdata = rdata1_q;

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Two-port arbiter and sequencer in front of the byte-wide data memory. It accepts 64-bit doubleword load/store requests from two requesters: port 0 is the core load/store path and port 1 is the debug/DMA path. Each accepted request is serialised into eight little-endian byte accesses on a single byte memory port. Access to that port is granted round-robin, and each request ends with a one-cycle response pulse carrying the read data or an error flag.

## Interface
- DEPTH, 16, memory size in bytes (power of two, at least 8)
- ADDR_W, 4, byte address width, equal to log2(DEPTH)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  request valid, N = 0, 1
- reqN_ready  out  1  request accepted this cycle when valid and ready are both high
- reqN_we  in  1  1 = store, 0 = load
- reqN_addr  in  64  byte base address
- reqN_wdata  in  64  store data; byte k goes to address base+k
- rspN_valid  out  1  one-cycle completion pulse
- rspN_err  out  1  address out of range; valid only with rspN_valid
- rspN_rdata  out  64  load data, held until that port's next response
- mem_addr  out  ADDR_W  byte address to memory
- mem_we  out  1  byte write strobe, written on the clk rising edge
- mem_wdata  out  8  byte write data
- mem_rdata  in  8  combinational byte read of mem_addr
- busy  out  1  high in XFER and RESP

## Operation
States: IDLE, XFER, RESP.

**Arbitration (IDLE only)**
- If exactly one port is valid, that port is granted.
- If both ports are valid, the port not served last is granted.
- last_grant resets to 1, so port 0 wins the first tie.
- reqN_ready is high only in IDLE and only for the granted port. Both ready signals are low in XFER and RESP.

**Accept**
- On valid && ready, latch addr, we, wdata and the port number, and update last_grant.
- If addr > DEPTH-8 (full 64-bit unsigned compare), the request is out of range: go directly to RESP with err=1 and issue no memory access.
- Otherwise clear the byte counter cnt and go to XFER.

**XFER**
- mem_addr = base[ADDR_W-1:0] + cnt.
- mem_we = latched we.
- mem_wdata = wdata byte cnt.
- On a load, mem_rdata is captured into rdata buffer byte cnt at the clock edge.
- cnt increments each cycle; after cnt==7 the state moves to RESP.
- Unaligned base addresses are legal as long as they are in range.

**RESP**
- One cycle. rsp_valid pulses on the granted port only; the other port's rsp outputs are unchanged.
- rsp_rdata is loaded from the buffer for a load, left unchanged for a store, and set to 0 on an error.
- The state then returns to IDLE.

**Other rules**
- A requester may drop valid while ready is low; nothing happens.
- A request held valid during XFER stays pending and is arbitrated on return to IDLE.
- Outside XFER: mem_we=0, mem_addr=0, mem_wdata=0.

## Timing
**Reset values:** state IDLE, cnt 0, last_grant 1, reqN_ready 0 (combinational from IDLE, so it asserts after reset deassertion if valid), rspN_valid 0, rspN_err 0, rspN_rdata 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0.

**Normal request:**
- Accept edge T.
- Byte k is accessed in cycle T+1+k (k = 0..7); the last byte is at T+8.
- rsp_valid is high in cycle T+9.
- The earliest next accept is T+10.
- Throughput is one doubleword per 10 cycles.

**Error request:** accept at T, rsp_valid with err=1 at T+1, next accept at T+2.

**Reset mid-operation:**
- All outputs return to their reset values immediately, without waiting for clk.
- The transaction is dropped with no response.
- Bytes already written stay in memory; the remaining bytes are not written.

**Other boundaries:**
- Simultaneous request on a port during its own RESP: not accepted until IDLE.
- There is no wrap-around: addr = DEPTH-8 is the last legal base address.

## Test plan
- **Load in range.** Memory preloaded with byte i = i. Load on port 0 at addr 0 -> rsp0_valid at accept+9, rdata = 0x0706050403020100, err = 0.
- **Store then load, unaligned base.** Port 1 stores 0x1122334455667788 at addr 5 -> mem_we high for 8 cycles at mem_addr 5..12 with bytes 0x88..0x11. A following port 0 load at addr 5 returns 0x1122334455667788.
- **Round-robin.** Both ports hold valid continuously from reset -> grants in the order 0, 1, 0, 1. Responses arrive 10 cycles apart, and ready never goes high on both ports in the same cycle.
- **Out of range.** Load at addr 9, then at 0xFFFFFFFF_FFFFFFF8 -> each gives rsp_valid at accept+1 with err = 1 and rdata = 0. mem_we stays 0 throughout; addr 8 gives err = 0.
- **Reset mid-write.** Store 0xAAAAAAAAAAAAAAAA at addr 0; assert reset_n low after 3 bytes -> outputs zero asynchronously and no rsp_valid. Memory bytes 0..2 = 0xAA and bytes 3..7 are unchanged. After reset the first tie is granted to port 0.
